// File: rtl/tt_pin_bus_bridge.sv
// Bridges a core load/store transaction onto a narrow strobe/ack pin bus, LS beat first.
// Define BRIDGE_TIMEOUT_EN to abort a transaction after TIMEOUT_CYC stalled cycles on one beat.
module tt_pin_bus_bridge #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  output logic              core_err,
  output logic [PIN_W-1:0]  pin_out,
  output logic              pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  output logic [1:0]        pin_phase,
  output logic              pin_stb,
  input  logic              pin_ack
);

  localparam int unsigned ABeats   = (ADDR_W + PIN_W - 1) / PIN_W;
  localparam int unsigned DBeats   = (DATA_W + PIN_W - 1) / PIN_W;
  localparam int unsigned AbufW    = ABeats * PIN_W;
  localparam int unsigned DbufW    = DBeats * PIN_W;
  localparam int unsigned MaxBeats = (ABeats > DBeats) ? ABeats : DBeats;
  localparam int unsigned CntW     = $clog2(MaxBeats + 1);

  localparam logic [CntW-1:0] ALast = CntW'(ABeats - 1);
  localparam logic [CntW-1:0] DLast = CntW'(DBeats - 1);

  localparam logic [1:0] PhIdle  = 2'b00;
  localparam logic [1:0] PhAddr  = 2'b01;
  localparam logic [1:0] PhWdata = 2'b10;
  localparam logic [1:0] PhRdata = 2'b11;

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRdata, StDone} state_e;

  state_e            state_q;
  logic              we_q;
  logic [CntW-1:0]   beat_q;
  logic [AbufW-1:0]  addr_q;
  logic [DbufW-1:0]  data_q;
  logic [DbufW-1:0]  rbuf_q;

  logic [AbufW-1:0]  addr_pad;
  logic [AbufW-1:0]  addr_shift;
  logic [DbufW-1:0]  wdata_pad;
  logic [DbufW-1:0]  data_shift;
  logic [DbufW-1:0]  rbuf_upd;
  logic              beat_ack;

  // Zero-extension pads short final beats in the MS bits.
  assign addr_pad   = AbufW'(core_addr);
  assign wdata_pad  = DbufW'(core_wdata);
  assign addr_shift = addr_q >> PIN_W;
  assign data_shift = data_q >> PIN_W;
  assign beat_ack   = pin_stb & pin_ack;

  // Read beats enter at the MS slot; after DBeats shifts the first beat sits at the LS end.
  assign rbuf_upd = (rbuf_q >> PIN_W) | (DbufW'(pin_in) << (DbufW - PIN_W));

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned    ScW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ScW-1:0] StallLast = ScW'(TIMEOUT_CYC - 1);

  logic [ScW-1:0] stall_q;
  logic           timeout;

  assign timeout = pin_stb & ~pin_ack & (stall_q == StallLast);
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign core_err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      beat_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rbuf_q     <= '0;
      core_rdata <= '0;
      core_done  <= 1'b0;
      pin_out    <= '0;
      pin_oe     <= 1'b0;
      pin_phase  <= PhIdle;
      pin_stb    <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      core_err   <= 1'b0;
      stall_q    <= '0;
`endif
    end else begin
      core_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (core_req) begin
            we_q      <= core_we;
            addr_q    <= addr_pad;
            data_q    <= wdata_pad;
            beat_q    <= '0;
            pin_out   <= addr_pad[PIN_W-1:0];
            pin_oe    <= 1'b1;
            pin_stb   <= 1'b1;
            pin_phase <= PhAddr;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (beat_ack) begin
            addr_q <= addr_shift;
            if (beat_q == ALast) begin
              beat_q <= '0;
              if (we_q) begin
                pin_out   <= data_q[PIN_W-1:0];
                pin_phase <= PhWdata;
                state_q   <= StWdata;
              end else begin
                pin_out   <= '0;
                pin_oe    <= 1'b0;
                pin_phase <= PhRdata;
                state_q   <= StRdata;
              end
            end else begin
              beat_q  <= beat_q + CntW'(1);
              pin_out <= addr_shift[PIN_W-1:0];
            end
          end
        end
        StWdata: begin
          if (beat_ack) begin
            data_q <= data_shift;
            if (beat_q == DLast) begin
              beat_q    <= '0;
              pin_out   <= '0;
              pin_oe    <= 1'b0;
              pin_stb   <= 1'b0;
              pin_phase <= PhIdle;
              core_done <= 1'b1;
              state_q   <= StDone;
            end else begin
              beat_q  <= beat_q + CntW'(1);
              pin_out <= data_shift[PIN_W-1:0];
            end
          end
        end
        StRdata: begin
          if (beat_ack) begin
            rbuf_q <= rbuf_upd;
            if (beat_q == DLast) begin
              beat_q     <= '0;
              core_rdata <= rbuf_upd[DATA_W-1:0];
              pin_stb    <= 1'b0;
              pin_phase  <= PhIdle;
              core_done  <= 1'b1;
              state_q    <= StDone;
            end else begin
              beat_q <= beat_q + CntW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
`ifdef BRIDGE_TIMEOUT_EN
      if (state_q == StDone) begin
        core_err <= 1'b0;
      end
      if (state_q == StIdle || beat_ack) begin
        stall_q <= '0;
      end else if (pin_stb) begin
        stall_q <= stall_q + ScW'(1);
      end
      // Abort overrides whatever the beat states scheduled above.
      if (timeout) begin
        stall_q    <= '0;
        beat_q     <= '0;
        core_rdata <= '0;
        core_err   <= 1'b1;
        core_done  <= 1'b1;
        pin_out    <= '0;
        pin_oe     <= 1'b0;
        pin_stb    <= 1'b0;
        pin_phase  <= PhIdle;
        state_q    <= StDone;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tt_pin_bus_bridge.sv
// Self-checking bench for tt_pin_bus_bridge: directed and random transactions against a beat-list model.
// A second instance covers odd address/data widths with padded final beats.
module tb_tt_pin_bus_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 8;
  localparam int unsigned NA = (AW + PW - 1) / PW;
  localparam int unsigned ND = (DW + PW - 1) / PW;

  localparam int unsigned OAW = 12;
  localparam int unsigned ODW = 20;
  localparam int unsigned ONA = (OAW + PW - 1) / PW;
  localparam int unsigned OND = (ODW + PW - 1) / PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_done, core_err;
  logic [PW-1:0] pin_out, pin_in;
  logic          pin_oe, pin_stb, pin_ack;
  logic [1:0]    pin_phase;

  logic           o_req, o_we;
  logic [OAW-1:0] o_addr;
  logic [ODW-1:0] o_wdata, o_rdata;
  logic           o_done, o_err;
  logic [PW-1:0]  o_out, o_in;
  logic           o_oe, o_stb, o_ack;
  logic [1:0]     o_phase;

  always #5 clk = ~clk;

  tt_pin_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .PIN_W(PW), .TIMEOUT_CYC(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_done  (core_done),
    .core_err   (core_err),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .pin_in     (pin_in),
    .pin_phase  (pin_phase),
    .pin_stb    (pin_stb),
    .pin_ack    (pin_ack)
  );

  tt_pin_bus_bridge #(.ADDR_W(OAW), .DATA_W(ODW), .PIN_W(PW), .TIMEOUT_CYC(4)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .core_req   (o_req),
    .core_we    (o_we),
    .core_addr  (o_addr),
    .core_wdata (o_wdata),
    .core_rdata (o_rdata),
    .core_done  (o_done),
    .core_err   (o_err),
    .pin_out    (o_out),
    .pin_oe     (o_oe),
    .pin_in     (o_in),
    .pin_phase  (o_phase),
    .pin_stb    (o_stb),
    .pin_ack    (o_ack)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rdata_hold = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ack always high; 1: random ack; 2: 3-cycle stall on the second write-data beat.
  task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [DW-1:0] rword, input int mode, output int lat);
    logic [PW-1:0] exp_out[$];
    logic [1:0]    exp_ph[$];
    int            nb, idx, stalls, k;
    bit            ack, done_seen;
    for (int i = 0; i < int'(NA); i++) begin
      exp_out.push_back(PW'(addr >> (PW * i)));
      exp_ph.push_back(2'b01);
    end
    for (int i = 0; i < int'(ND); i++) begin
      exp_out.push_back(we ? PW'(wdata >> (PW * i)) : '0);
      exp_ph.push_back(we ? 2'b10 : 2'b11);
    end
    nb = exp_out.size();
    idx = 0; stalls = 0; k = 0; done_seen = 0; lat = -1;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    while (!done_seen && k < 300) begin
      @(negedge clk);
      k++;
      if (idx < nb) begin
        check("stb", pin_stb, 1);
        check("phase", pin_phase, exp_ph[idx]);
        check("out", pin_out, exp_out[idx]);
        check("oe", pin_oe, exp_ph[idx] != 2'b11);
        check("early_done", core_done, 0);
        case (mode)
          0:       ack = 1'b1;
          1:       ack = ($urandom_range(3) != 0);
          default: ack = !(idx == int'(NA) + 1 && stalls < 3);
        endcase
        pin_ack = ack;
        pin_in  = (ack && !we && idx >= int'(NA)) ? PW'(rword >> (PW * (idx - int'(NA))))
                                                 : PW'($urandom);
        if (ack) idx++;
        else stalls++;
      end else begin
        done_seen = 1'b1;
        lat = k;
        if (!we) rdata_hold = rword;
        check("done", core_done, 1);
        check("err", core_err, 0);
        check("rdata", core_rdata, rdata_hold);
        check("done_stb", pin_stb, 0);
        check("done_oe", pin_oe, 0);
        check("done_phase", pin_phase, 0);
        check("latency", k, 1 + nb + stalls);
        core_req = 1'b0;
        pin_ack  = 1'(($urandom_range(1)));
      end
    end
    if (!done_seen) check("done_bound", core_done, 1);
    @(negedge clk);
    check("done_pulse", core_done, 0);
    check("idle_stb", pin_stb, 0);
  endtask

  task automatic odd_txn(input bit we, input logic [OAW-1:0] addr, input logic [ODW-1:0] wdata,
                         input logic [OND*PW-1:0] rbeats);
    logic [PW-1:0] exp_out[$];
    logic [ODW-1:0] exp_rd;
    int            nb;
    for (int i = 0; i < int'(ONA); i++) exp_out.push_back(PW'(addr >> (PW * i)));
    for (int i = 0; i < int'(OND); i++) exp_out.push_back(we ? PW'(wdata >> (PW * i)) : '0);
    nb = exp_out.size();
    exp_rd = rbeats[ODW-1:0];
    @(negedge clk);
    o_req = 1'b1; o_we = we; o_addr = addr; o_wdata = wdata; o_ack = 1'b1;
    for (int k = 1; k <= nb; k++) begin
      @(negedge clk);
      check("odd_out", o_out, exp_out[k-1]);
      check("odd_phase", o_phase, (k <= int'(ONA)) ? 2'b01 : (we ? 2'b10 : 2'b11));
      check("odd_early_done", o_done, 0);
      o_in = (k > int'(ONA)) ? PW'(rbeats >> (PW * (k - 1 - int'(ONA)))) : '0;
    end
    @(negedge clk);
    check("odd_done", o_done, 1);
    if (!we) check("odd_rdata", o_rdata, exp_rd);
    o_req = 1'b0; o_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    pin_in = '0; pin_ack = 0;
    o_req = 0; o_we = 0; o_addr = '0; o_wdata = '0; o_in = '0; o_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_stb", pin_stb, 0);
    check("rst_oe", pin_oe, 0);
    check("rst_phase", pin_phase, 0);
    check("rst_out", pin_out, 0);
    check("rst_done", core_done, 0);
    check("rst_rdata", core_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b1, 16'h1234, 32'hDEADBEEF, '0, 0, lat);
    check("write_lat", lat, 7);
    txn(1'b0, 16'h00A5, '0, 32'h44332211, 0, lat);
    check("read_lat", lat, 7);
    check("read_word", core_rdata, 32'h44332211);
    txn(1'b1, 16'h1234, 32'hDEADBEEF, '0, 2, lat);
    check("stall_lat", lat, 10);

    // Reset during the third read-data beat.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0F0F; pin_ack = 1'b1; pin_in = 8'h5A;
    repeat (NA + 3) @(negedge clk);
    check("pre_rst_phase", pin_phase, 2'b11);
    rst = 1'b1; core_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; rdata_hold = '0;
    check("mid_rst_stb", pin_stb, 0);
    check("mid_rst_phase", pin_phase, 0);
    check("mid_rst_out", pin_out, 0);
    check("mid_rst_oe", pin_oe, 0);
    check("mid_rst_rdata", core_rdata, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (core_done) seen = 1;
    end
    check("mid_rst_no_done", seen, 0);
    txn(1'b1, 16'hBEEF, 32'h0BADF00D, '0, 0, lat);

    for (int n = 0; n < 24; n++) begin
      txn(1'($urandom_range(1)), AW'($urandom), DW'($urandom), DW'($urandom), 1, lat);
    end

    // Never acknowledge a beat.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h4321; pin_ack = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        check("to_wait", core_done, 0);
      end else begin
        check("to_done", core_done, 1);
        check("to_err", core_err, 1);
        check("to_rdata", core_rdata, 0);
        core_req = 1'b0; rdata_hold = '0;
      end
    end
    @(negedge clk);
    check("to_pulse", core_done, 0);
    check("to_err_clr", core_err, 0);
`else
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (core_done) seen = 1;
    end
    check("no_timeout_done", seen, 0);
    check("no_timeout_stb", pin_stb, 1);
    core_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rdata_hold = '0;
`endif
    txn(1'b0, 16'h8001, '0, 32'hCAFE0123, 0, lat);

    odd_txn(1'b1, 12'hABC, 20'hFFFFF, '0);
    odd_txn(1'b0, 12'h123, '0, 24'hF7C35A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_pin_bus_bridge.md
Name: tt_pin_bus_bridge

Overview:
- Parametrised successor to the fixed 8-bit pin hookup between the TinyTapeout top-level pins and the MIPS SoC.
- Carries a core-side bus transaction of arbitrary address and data width over a narrow pin bus.
- Splits each transfer into PIN_W-wide beats, LS beat first, using a strobe/ack handshake.
- Sits between the core load/store port and the ui_in/uo_out/uio pins.

Parameters:
ADDR_W, 16, core address width (bits)
DATA_W, 32, core data width (bits)
PIN_W, 8, pin bus width per beat
TIMEOUT_CYC, 255, stall cycles per beat before abort (used only with BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_req  in  1  transaction request; held with fields stable until core_done
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  address
core_wdata  in  DATA_W  write data
core_rdata  out  DATA_W  read data, valid in core_done cycle, held until next done
core_done  out  1  one-cycle completion pulse
core_err  out  1  valid with core_done; 1=aborted
pin_out  out  PIN_W  outgoing beat
pin_oe  out  1  1 while bridge drives pin_out
pin_in  in  PIN_W  incoming read beat
pin_phase  out  2  00 idle, 01 addr, 10 wdata, 11 rdata
pin_stb  out  1  beat valid/request
pin_ack  in  1  external beat acknowledge

Behaviour:
- Interface fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Derived constants: ABEATS = ceil(ADDR_W/PIN_W), DBEATS = ceil(DATA_W/PIN_W).
- Short final beats are zero-padded in the MS bits. On reads, the padding bits of pin_in are ignored.
- Reset values: all outputs 0, core_rdata 0, FSM in IDLE, beat counter 0.
- States: IDLE, ADDR, WDATA, RDATA, DONE.
- IDLE: when core_req=1, latch we/addr/wdata into shift registers and go to ADDR. No new request is sampled outside IDLE.
- ADDR: pin_stb=1, pin_oe=1, pin_phase=01, pin_out = current addr beat.
  - Each cycle with pin_stb & pin_ack: shift and increment the beat counter.
  - After beat ABEATS-1 is acked: go to WDATA if we=1, else RDATA.
- WDATA: same as ADDR with pin_phase=10 and data beats. After DBEATS acks, go to DONE.
- RDATA: pin_stb=1, pin_oe=0, pin_out=0, pin_phase=11.
  - On each ack, capture pin_in into the next LS-first slot of the read buffer.
  - After DBEATS acks, go to DONE.
- DONE: one cycle.
  - core_done=1 and core_err=0.
  - core_rdata takes the assembled word on reads; it is unchanged on writes.
  - pin_stb=0, pin_oe=0, pin_phase=00.
  - Next state is IDLE.
  - If core_req is still high in the following IDLE cycle, it is a new transaction.
- Latency with pin_ack tied 1 (req seen high in IDLE at cycle T):
  - First ADDR beat at T+1.
  - core_done at T+1+ABEATS+DBEATS.
  - Default parameters: T+7 for both reads and writes.
- pin_ack while pin_stb=0 is ignored.
- pin_ack held high gives back-to-back beats, one per cycle.
- pin_ack low stalls: pin_out and pin_phase are held stable.
- rst asserted mid-transaction: return to IDLE next edge, all outputs reset, no core_done, partial read data discarded.
- ADDR_W or DATA_W an exact multiple of PIN_W: no padding.
- PIN_W >= width: single beat.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- Defined:
  - A stall counter increments each cycle with pin_stb=1 & pin_ack=0, and clears on every ack and in IDLE.
  - When the counter reaches TIMEOUT_CYC, the FSM goes to DONE with core_err=1 and core_rdata forced to 0.
- Not defined:
  - No counter logic; core_err is tied 0.
  - The bridge waits indefinitely for pin_ack.

Test Plan:
- Write, ack tied 1, addr=0x1234, wdata=0xDEADBEEF -> beats 34,12 (phase 01) then EF,BE,AD,DE (phase 10); core_done at T+7, err=0.
- Read, ack tied 1, addr=0x00A5, pin_in per beat 11,22,33,44 -> core_rdata=0x44332211 at done.
- Stall: ack low 3 cycles on the second wdata beat -> pin_out=BE and pin_phase=10 held stable; done delayed by exactly 3 cycles.
- Reset: rst pulsed during the third RDATA beat -> next cycle all outputs 0 and IDLE; no done. A following write completes normally.
- Odd widths ADDR_W=12, DATA_W=20, PIN_W=8, addr=0xABC -> addr beats BC,0A; 3 data beats; write 0xFFFFF -> beats FF,FF,0F.
- BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=4, ack never asserted -> core_done with core_err=1 and core_rdata=0 at T+1+4; with the macro undefined, no done after 100 cycles.
